// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply/divide unit (shift-add / restoring divide)
// Divide datapath present only when MDU_DIV_EN is defined.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [XLEN-1:0]   acc_hi, acc_lo, mcand;
    logic [5:0]        cnt;
    logic              neg_q;
    logic              accept, is_signed, a_neg, b_neg, bypass;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod;

    assign accept    = start && (state == IDLE || state == DONE);
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[XLEN-1];
    assign b_neg     = is_signed & b[XLEN-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign prod      = {acc_hi, acc_lo};

`ifdef MDU_DIV_EN
    logic            is_div, neg_r, b_zero;
    logic [XLEN-1:0] a_raw, div_sub;
    logic [XLEN:0]   div_shift;
    logic            div_fits;

    assign bypass    = 1'b0;
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_fits  = div_shift >= {1'b0, mcand};
    // The remainder after a successful subtract is below the divisor, so it fits in XLEN bits.
    assign div_sub   = div_shift[XLEN-1:0] - mcand;
`else
    assign bypass    = op[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = bypass ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            RUN:     if (cnt == 6'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi      <= '0;
            acc_lo      <= '0;
            mcand       <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
`ifdef MDU_DIV_EN
            is_div      <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            a_raw       <= '0;
`endif
        end else if (accept) begin
            acc_hi <= '0;
            acc_lo <= a_mag;
            mcand  <= b_mag;
            cnt    <= '0;
            neg_q  <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
            is_div <= op[1];
            neg_r  <= a_neg & op[1];
            b_zero <= (b == '0);
            a_raw  <= a;
`else
            if (op[1]) begin
                hi          <= '0;
                lo          <= '0;
                div_by_zero <= 1'b0;
            end
`endif
        end else if (state == RUN) begin
            cnt <= cnt + 6'd1;
`ifdef MDU_DIV_EN
            if (is_div) begin
                acc_hi <= div_fits ? div_sub : div_shift[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], div_fits};
            end else
`endif
            begin
                acc_hi <= mul_sum[XLEN:1];
                acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
        end else if (state == FIX) begin
`ifdef MDU_DIV_EN
            if (is_div) begin
                if (b_zero) begin
                    lo          <= '1;
                    hi          <= a_raw;
                    div_by_zero <= 1'b1;
                end else begin
                    lo          <= neg_q ? -acc_lo : acc_lo;
                    hi          <= neg_r ? -acc_hi : acc_hi;
                    div_by_zero <= 1'b0;
                end
            end else
`endif
            begin
                {hi, lo}    <= neg_q ? -prod : prod;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, div_by_zero;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;

    int checks = 0;
    int errors = 0;

    int          pulse_at = 0;
    bit          b2b = 1'b0;
    logic [1:0]  op2;
    logic [31:0] a2, b2;

    mul_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, y,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output logic edbz, output int elat, output int ebusy);
        logic [63:0] p;
        int sx, sy;
        edbz = 1'b0; elat = 34; ebusy = 33;
        sx = x; sy = y;
        if (o == 2'd0) begin
            p = 64'(longint'(sx) * longint'(sy));
            {ehi, elo} = p;
        end else if (o == 2'd1) begin
            p = {32'h0, x} * {32'h0, y};
            {ehi, elo} = p;
        end else begin
`ifdef MDU_DIV_EN
            if (y == 32'h0) begin
                elo = 32'hFFFF_FFFF; ehi = x; edbz = 1'b1;
            end else if (o == 2'd3) begin
                elo = x / y; ehi = x % y;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                elo = 32'h8000_0000; ehi = 32'h0;
            end else begin
                elo = 32'(sx / sy); ehi = 32'(sx % sy);
            end
`else
            elo = 32'h0; ehi = 32'h0; elat = 1; ebusy = 0;
`endif
        end
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ehi, elo, ehi2, elo2, ghi, glo, ghi2, glo2;
        logic        edbz, edbz2, gdbz, gdbz2;
        int elat, ebusy, elat2, ebusy2, lat, lat2, busy_cnt, done_cnt, win;
        model(o, x, y, ehi, elo, edbz, elat, ebusy);
        ehi2 = 0; elo2 = 0; edbz2 = 0; elat2 = 0; ebusy2 = 0;
        if (b2b) model(op2, a2, b2, ehi2, elo2, edbz2, elat2, ebusy2);
        win = b2b ? 75 : 40;
        lat = 0; lat2 = 0; busy_cnt = 0; done_cnt = 0;
        ghi = 0; glo = 0; gdbz = 0; ghi2 = 0; glo2 = 0; gdbz2 = 0;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= win; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                if (done_cnt == 0) begin
                    lat = n; ghi = hi; glo = lo; gdbz = div_by_zero;
                end else if (done_cnt == 1) begin
                    lat2 = n; ghi2 = hi; glo2 = lo; gdbz2 = div_by_zero;
                end
                done_cnt++;
            end
            if (n == 1 && !b2b) begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
            if (pulse_at != 0 && n == pulse_at) start = 1'b1;
            if (pulse_at != 0 && n == pulse_at + 1) start = 1'b0;
            if (b2b && n == 34) begin
                op = op2; a = a2; b = b2;
            end
            if (b2b && n == 35) start = 1'b0;
        end
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_busy"}, 64'(busy_cnt), 64'(ebusy + ebusy2));
        check({tag, "_ndone"}, 64'(done_cnt), b2b ? 64'd2 : 64'd1);
        check({tag, "_hi"}, {32'h0, ghi}, {32'h0, ehi});
        check({tag, "_lo"}, {32'h0, glo}, {32'h0, elo});
        check({tag, "_dbz"}, {63'h0, gdbz}, {63'h0, edbz});
        if (b2b) begin
            check({tag, "_lat2"}, 64'(lat2), 64'(elat + elat2));
            check({tag, "_hi2"}, {32'h0, ghi2}, {32'h0, ehi2});
            check({tag, "_lo2"}, {32'h0, glo2}, {32'h0, elo2});
            check({tag, "_dbz2"}, {63'h0, gdbz2}, {63'h0, edbz2});
        end
        check({tag, "_hold"}, {hi, lo}, b2b ? {ehi2, elo2} : {ehi, elo});
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; a = 32'h0; b = 32'h0;
        op2 = 2'd0; a2 = 32'h0; b2 = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_hilo", {hi, lo}, 64'h0);
        check("rst_dbz", {63'h0, div_by_zero}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 2'd3, 32'd100, 32'd7);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_zero", 2'd3, 32'h1234_5678, 32'h0);
        run_op("multu_2_3", 2'd1, 32'd2, 32'd3);

        pulse_at = 10;
        run_op("restart_ign", 2'd1, $urandom, $urandom);
        pulse_at = 0;

        b2b = 1'b1; op2 = 2'd1; a2 = $urandom; b2 = $urandom;
        run_op("b2b", 2'd1, $urandom, $urandom);
        b2b = 1'b0;

        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);

        // Abort a divide mid-run with an asynchronous reset.
        op = 2'd2; a = $urandom; b = $urandom | 32'h1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_hilo", {hi, lo}, 64'h0);
        check("abort_dbz", {63'h0, div_by_zero}, 64'h0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_nodone", 64'(done_seen), 64'h0);
        run_op("divu_9_3", 2'd3, 32'd9, 32'd3);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
